// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, oversampling constants and baud divider helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int SAMPLE_MID = 7;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Clocks per 16x tick; truncated, never below one so the tick always fires.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with first-word-fall-through head.
// Latency: a push is visible on head_dat/empty/level the cycle after it is written.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  // Qualify push/pop and advance pointers; pointers wrap naturally mod DEPTH.
  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    pop_en   = pop & ~empty;
    push_en  = push & (~full | pop_en);
    wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    head_dat = mem_q[rd_ptr_q];
    level    = level_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 16x-oversampled UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined) into a byte FIFO.
// Latency: byte pushed on the stop-bit mid-sample cycle; m_valid/m_data/fifo_level update one cycle later.
// Backpressure: m_valid/m_ready stream; with the FIFO full a new byte is dropped and overrun pulses.
module uart_rx_capture #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk100,
  input  logic                        sys_rst,
  input  logic                        rx,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err
);

  import uart_pkg::*;

  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic              sync1_q, sync1_d;
  logic              rx_s_q, rx_s_d;
  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        samp_cnt_q, samp_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              tick, mid, push, par_bad;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_head;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign par_bad    = par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Synchroniser, tick divider and sample counter; phase realigns whenever idle.
  always_comb begin
    sync1_d    = rx;
    rx_s_d     = sync1_q;
    tick       = (tick_cnt_q == TICK_W'(DIV - 1));
    mid        = tick && (samp_cnt_q == 4'(SAMPLE_MID));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    samp_cnt_d = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
    if (state_q == IDLE) begin
      tick_cnt_d = '0;
      samp_cnt_d = '0;
    end
    overrun_d = push & fifo_full & ~(m_ready & ~fifo_empty);
  end

  // Frame FSM: next state, shift register and error pulses.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (mid) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (mid) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) begin
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (mid) begin
          if (rx_s_q) begin
            push    = ~par_bad;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchroniser resets to the idle-high line level.
  always_ff @(posedge clk100) begin
    if (sys_rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity fault is held until the stop bit so both errors report together.
  always_ff @(posedge clk100) begin
    if (sys_rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk100),
    .rst      (sys_rst),
    .push     (push),
    .push_dat (shift_q),
    .pop      (m_ready),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign m_valid   = ~fifo_empty;
  assign m_data    = fifo_empty ? 8'h00 : fifo_head;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: drives serial frames (DIV=1, 16 clk/bit, FIFO depth 4) and checks the byte stream.
// Latency: expects the byte one cycle after the stop-bit mid-sample.
// Backpressure: exercises overrun, same-cycle pop-and-push, and random m_ready.
module tb_uart_rx_capture;

  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_C = 16 * NBITS;
  localparam int PUSH_C  = 10 + 16 * (NBITS - 1);

  logic       clk100 = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic [2:0] fifo_level;
  logic       frame_err, overrun, parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rcv_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic rdy_rand = 1'b0;
  logic snap_v_pre, snap_v_post;
  logic [7:0] snap_d_post;
  logic [2:0] snap_l_post;

  uart_rx_capture #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk100     (clk100),
    .sys_rst    (sys_rst),
    .rx         (rx),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial forever #5 clk100 = ~clk100;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer-side monitor: records accepted bytes and error pulses.
  always @(negedge clk100) begin
    if (m_valid && m_ready) rcv_q.push_back(m_data);
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
  end

  function automatic logic [7:0] rcv_at(input int i);
    return (i < rcv_q.size()) ? rcv_q[i] : 8'hxx;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic drain(input int n);
    m_ready = 1'b1;
    cyc(n);
    m_ready = 1'b0;
  endtask

  // Drives one frame bit-by-bit for ncyc clocks; snapshots outputs around the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                            input logic pulse, input int ncyc);
    logic [NBITS-1:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
    fr[9] = (^b) ^ par_flip;
`else
    if (par_flip) fr[0] = 1'b0;
`endif
    fr[NBITS-1] = stop_b;
    for (int c = 0; c < ncyc; c++) begin
      rx = fr[c / 16];
      if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
      else if (pulse) m_ready = (c == PUSH_C);
      @(negedge clk100);
      if (c == PUSH_C) snap_v_pre = m_valid;
      if (c == PUSH_C + 1) begin
        snap_v_post = m_valid;
        snap_d_post = m_data;
        snap_l_post = fifo_level;
      end
      @(posedge clk100);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    cyc(3);
    @(negedge clk100);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err}); end
    cyc(1);
    sys_rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_basic();
    int r0;
    r0 = rcv_q.size();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, FRAME_C);
    checks++; if (snap_v_pre !== 1'b0) begin errors++; $display("FAIL basic_valid_before: got %b expected 0", snap_v_pre); end
    checks++; if (snap_v_post !== 1'b1) begin errors++; $display("FAIL basic_valid_after: got %b expected 1", snap_v_post); end
    checks++; if (snap_d_post !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", snap_d_post); end
    checks++; if (snap_l_post !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d expected 1", snap_l_post); end
    drain(4);
    checks++; if (rcv_q.size() - r0 !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", rcv_q.size() - r0); end
    checks++; if (rcv_at(r0) !== 8'hA5) begin errors++; $display("FAIL basic_popped: got %h expected a5", rcv_at(r0)); end
  endtask

  task automatic test_glitch();
    int r0, fe0, ov0, pe0;
    r0 = rcv_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(40);
    checks++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)); end
    @(negedge clk100);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL glitch_level: got %0d expected 0", fifo_level); end
    cyc(1);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, FRAME_C);
    drain(4);
    checks++; if (rcv_q.size() - r0 !== 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", rcv_q.size() - r0); end
    checks++; if (rcv_at(r0) !== 8'h96) begin errors++; $display("FAIL glitch_next_byte: got %h expected 96", rcv_at(r0)); end
  endtask

  task automatic test_frame_err();
    int r0, fe0;
    r0 = rcv_q.size(); fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, FRAME_C);
    rx = 1'b0;
    cyc(40);
    rx = 1'b1;
    cyc(20);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, FRAME_C);
    drain(4);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (rcv_q.size() - r0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", rcv_q.size() - r0); end
    checks++; if (rcv_at(r0) !== 8'h5A) begin errors++; $display("FAIL ferr_next_byte: got %h expected 5a", rcv_at(r0)); end
  endtask

  task automatic test_overrun();
    logic [7:0] mdl[$];
    logic [7:0] exp_out[$];
    int r0, ov0, exp_ov;
    r0 = rcv_q.size(); ov0 = ov_cnt; exp_ov = 0;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0, FRAME_C);
      if (mdl.size() < DEPTH) mdl.push_back(8'(i)); else exp_ov++;
    end
    @(negedge clk100);
    checks++; if (fifo_level !== 3'(mdl.size())) begin errors++; $display("FAIL ovr_level: got %0d expected %0d", fifo_level, mdl.size()); end
    cyc(1);
    checks++; if (ov_cnt - ov0 !== exp_ov) begin errors++; $display("FAIL ovr_pulses: got %0d expected %0d", ov_cnt - ov0, exp_ov); end
    drain(10);
    checks++; if (rcv_q.size() - r0 !== mdl.size()) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", rcv_q.size() - r0, mdl.size()); end
    for (int i = 0; i < mdl.size(); i++) begin
      checks++; if (rcv_at(r0 + i) !== mdl[i]) begin errors++; $display("FAIL ovr_order[%0d]: got %h expected %h", i, rcv_at(r0 + i), mdl[i]); end
    end
    // Refill, then pop exactly on the push cycle of the fifth byte.
    mdl.delete();
    r0 = rcv_q.size(); ov0 = ov_cnt; exp_ov = 0;
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0, FRAME_C);
      mdl.push_back(8'h11 + 8'(i));
    end
    send_frame(8'h15, 1'b1, 1'b0, 1'b1, FRAME_C);
    exp_out.push_back(mdl.pop_front());
    mdl.push_back(8'h15);
    @(negedge clk100);
    checks++; if (fifo_level !== 3'(mdl.size())) begin errors++; $display("FAIL ovr_pop_level: got %0d expected %0d", fifo_level, mdl.size()); end
    cyc(1);
    checks++; if (ov_cnt - ov0 !== exp_ov) begin errors++; $display("FAIL ovr_pop_pulses: got %0d expected 0", ov_cnt - ov0); end
    drain(10);
    while (mdl.size() > 0) exp_out.push_back(mdl.pop_front());
    checks++; if (rcv_q.size() - r0 !== exp_out.size()) begin errors++; $display("FAIL ovr_pop_count: got %0d expected %0d", rcv_q.size() - r0, exp_out.size()); end
    for (int i = 0; i < exp_out.size(); i++) begin
      checks++; if (rcv_at(r0 + i) !== exp_out[i]) begin errors++; $display("FAIL ovr_pop_order[%0d]: got %h expected %h", i, rcv_at(r0 + i), exp_out[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int r0, fe0;
    m_ready = 1'b0;
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, FRAME_C);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 72);
    sys_rst = 1'b1;
    rx = 1'b1;
    cyc(2);
    @(negedge clk100);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", m_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmid_level: got %0d expected 0", fifo_level); end
    cyc(1);
    sys_rst = 1'b0;
    cyc(20);
    r0 = rcv_q.size(); fe0 = fe_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, FRAME_C);
    drain(4);
    checks++; if (rcv_q.size() - r0 !== 1) begin errors++; $display("FAIL rmid_count: got %0d expected 1", rcv_q.size() - r0); end
    checks++; if (rcv_at(r0) !== 8'h81) begin errors++; $display("FAIL rmid_byte: got %h expected 81", rcv_at(r0)); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL rmid_ferr: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_parity();
    int r0, pe0, fe0;
    r0 = rcv_q.size(); pe0 = pe_cnt; fe0 = fe_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, FRAME_C);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, FRAME_C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, FRAME_C);
    drain(4);
    checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL par_pulses: got %0d expected 1", pe_cnt - pe0); end
    checks++; if (rcv_q.size() - r0 !== 2) begin errors++; $display("FAIL par_count: got %0d expected 2", rcv_q.size() - r0); end
    checks++; if (rcv_at(r0) !== 8'h07) begin errors++; $display("FAIL par_good: got %h expected 07", rcv_at(r0)); end
    checks++; if (rcv_at(r0 + 1) !== 8'h3C) begin errors++; $display("FAIL par_after_bad: got %h expected 3c", rcv_at(r0 + 1)); end
`else
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, FRAME_C);
    send_frame(8'hFE, 1'b1, 1'b0, 1'b0, FRAME_C);
    drain(4);
    checks++; if (pe_cnt !== 0) begin errors++; $display("FAIL par_tied_low: got %0d expected 0", pe_cnt); end
    checks++; if (rcv_q.size() - r0 !== 2) begin errors++; $display("FAIL par_count: got %0d expected 2", rcv_q.size() - r0); end
    checks++; if (rcv_at(r0 + 1) !== 8'hFE) begin errors++; $display("FAIL par_byte: got %h expected fe", rcv_at(r0 + 1)); end
`endif
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL par_ferr: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mdl[$];
    logic [7:0] b;
    int r0, ov0, fe0;
    r0 = rcv_q.size(); ov0 = ov_cnt; fe0 = fe_cnt;
    rdy_rand = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, 1'b0, FRAME_C);
      mdl.push_back(b);
      cyc($urandom_range(0, 3));
    end
    rdy_rand = 1'b0;
    drain(8);
    checks++; if (rcv_q.size() - r0 !== mdl.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", rcv_q.size() - r0, mdl.size()); end
    for (int i = 0; i < mdl.size(); i++) begin
      checks++; if (rcv_at(r0 + i) !== mdl[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, rcv_at(r0 + i), mdl[i]); end
    end
    checks++; if ((ov_cnt - ov0) + (fe_cnt - fe0) !== 0) begin errors++; $display("FAIL b2b_pulses: got %0d expected 0", (ov_cnt - ov0) + (fe_cnt - fe0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
